tt_mux_sel_driver: RTL and testbench
====================================

Name: tt_mux_sel_driver

Overview:
- Hardware initiator for the Tiny Tapeout project-mux select interface. It generates the `ctrl_sel_rst_n` / `ctrl_sel_inc` / `ctrl_ena` pin sequence that the on-chip mux controller decodes.
- Replaces firmware or bench bit-banging: given a target project address, it
  - drops enable,
  - resets the controller's address counter,
  - issues exactly `addr` increment pulses,
  - re-enables the selected design.
- Sits between a host-side command source and the three ctrl pads.

Parameters:
- `ADDR_W`, 10, width of the project address.
- `RST_CYCLES`, 4, `clk` cycles `ctrl_sel_rst_n` is held low (≥1).
- `PULSE_CYCLES`, 2, `clk` cycles for each high phase and each low phase of `ctrl_sel_inc`. Also the settle gap after reset (≥1).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a select; sampled only in IDLE.
- `addr`  in  ADDR_W  target project address; latched when `start` is accepted.
- `stop`  in  1  in IDLE: drives `ctrl_ena` low; ignored while busy.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse when `ctrl_ena` rises at the end of a select.
- `ctrl_sel_rst_n`  out  1  to mux controller; active-low counter reset.
- `ctrl_sel_inc`  out  1  to mux controller; counter increments on its rising edge.
- `ctrl_ena`  out  1  to mux controller; enables the selected design.

Behaviour:
- Reset values: `ctrl_sel_rst_n`=1, `ctrl_sel_inc`=0, `ctrl_ena`=0, `busy`=0, `done`=0. FSM state = IDLE, pulse counters = 0. All outputs are registered.
- Reset asserted mid-sequence aborts immediately to the reset values. No partial pulse is completed.
- FSM states: IDLE → DIS → RST → GAP → INC_HI ⇄ INC_LO → DONE → IDLE.
  - IDLE: waits for `start`=1, then latches `addr` into `tgt` and loads remaining count = `tgt`.
  - DIS: 1 cycle. `ctrl_ena`=0.
  - RST: `RST_CYCLES` cycles. `ctrl_sel_rst_n`=0.
  - GAP: `PULSE_CYCLES` cycles. `ctrl_sel_rst_n`=1, `ctrl_sel_inc`=0.
  - INC_HI / INC_LO: `PULSE_CYCLES` cycles each. `ctrl_sel_inc`=1 in INC_HI, 0 in INC_LO. Remaining count decrements on leaving INC_LO.
  - After GAP or INC_LO: if remaining=0 go to DONE, else INC_HI. So `addr`=0 produces no inc pulses.
  - DONE: 1 cycle. `ctrl_ena`=1, `done`=1.
- `ctrl_ena` stays 1 through IDLE until the next accepted `start` (it drops in DIS) or `stop`=1 in IDLE. `stop` and `start` asserted together in IDLE: `start` wins.
- `busy`=1 from the cycle after `start` is accepted through the DONE cycle. `start` is ignored while `busy`=1; it is not queued.
- Timing: with `start` sampled at edge 0, DIS occupies cycle 1 and `done` is high in cycle 2 + R + P + 2·P·N, where R = `RST_CYCLES`, P = `PULSE_CYCLES`, N = `addr`.
- `ctrl_sel_inc` is never high while `ctrl_sel_rst_n`=0.
- `addr` = 2^ADDR_W − 1 is legal. Counters are sized so that case does not wrap.

Optional Feature:
- Macro: `MUX_SEL_INCREMENTAL_EN`.
- With the macro defined:
  - A shadow register `cur` holds the last completed address, with a valid flag cleared by `rst_n`.
  - `cur` is set to `tgt` in DONE, and output on an added port `cur_addr` [ADDR_W].
  - When `start` is accepted with valid=1 and `addr` ≥ `cur`, the FSM goes IDLE → DIS → INC/DONE. RST and GAP are skipped, and exactly `addr` − `cur` pulses are issued.
  - `addr` < `cur` or valid=0 takes the full sequence.
- Without the macro: the full sequence always runs and there is no `cur_addr` port.

Test Plan:
- Reset: hold `rst_n`=0 → `ctrl_sel_rst_n`=1, `ctrl_sel_inc`=0, `ctrl_ena`=0, `busy`=0.
- `start` with `addr`=3, defaults → `ctrl_sel_rst_n` low for 4 cycles, then exactly 3 `ctrl_sel_inc` pulses of 2 high / 2 low cycles, `done` and `ctrl_ena` rise in cycle 20, `busy` low in cycle 21.
- `addr`=0 → reset pulse, no inc pulses, `done` in cycle 8. `addr`=1023 → exactly 1023 rising edges on `ctrl_sel_inc`.
- `start` re-asserted while `busy` → no effect on pulse count. `stop` in IDLE after a select → `ctrl_ena`=0 next cycle.
- `rst_n` pulsed low during the INC phase of `addr`=5 → outputs return to reset values at once. A following `start` with `addr`=2 gives a clean full sequence.
- With `MUX_SEL_INCREMENTAL_EN`: select 4, then 6 → second select has no `ctrl_sel_rst_n` low and exactly 2 pulses, `cur_addr`=6. Then select 1 → full sequence, `cur_addr`=1.

Source files
------------

// File: rtl/tt_mux_sel_driver.sv
// -----------------------------------------------------------------------------
// tt_mux_sel_driver
//
// Hardware initiator for the Tiny Tapeout project-mux select interface. Given a
// target project address it drops ctrl_ena, resets the mux controller's
// address counter, issues exactly `addr` increment pulses on ctrl_sel_inc and
// then re-enables the selected design.
//
// Sequence: IDLE -> DIS -> RST -> GAP -> INC_HI <-> INC_LO -> DONE -> IDLE
//
// Parameters:
//   ADDR_W        width of the project address
//   RST_CYCLES    clk cycles ctrl_sel_rst_n is held low (>= 1)
//   PULSE_CYCLES  clk cycles per high / low phase of ctrl_sel_inc, and the
//                 settle gap after the counter reset (>= 1)
//
// Ports:
//   clk             single clock
//   rst_n           asynchronous active-low reset
//   start           request a select (sampled only in IDLE)
//   addr            target project address, latched when start is accepted
//   stop            in IDLE, drives ctrl_ena low; ignored while busy
//   busy            high in every non-IDLE state
//   done            one-cycle pulse when ctrl_ena rises at end of a select
//   ctrl_sel_rst_n  to mux controller, active-low counter reset
//   ctrl_sel_inc    to mux controller, counter increments on rising edge
//   ctrl_ena        to mux controller, enables the selected design
//   cur_addr        (MUX_SEL_INCREMENTAL_EN only) last completed address
//
// Optional feature, macro MUX_SEL_INCREMENTAL_EN:
//   Remembers the last completed address. A new select at or above it skips
//   the counter reset and only issues the difference in increment pulses.
//
// All outputs are registered; their next values are decoded from the
// next state so they line up exactly with the state they belong to.
// -----------------------------------------------------------------------------
module tt_mux_sel_driver #(
  parameter int ADDR_W       = 10,
  parameter int RST_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
`ifdef MUX_SEL_INCREMENTAL_EN
  ,
  output logic [ADDR_W-1:0] cur_addr
`endif
);

  // Phase counter only has to reach the longest timed phase minus one.
  localparam int CNT_MAX = (RST_CYCLES > PULSE_CYCLES) ? RST_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DIS,
    RST,
    GAP,
    INC_HI,
    INC_LO,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Remaining pulses; ADDR_W bits hold the all-ones address without wrapping.
  logic [ADDR_W-1:0] rem_q, rem_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sel_rst_n_q, sel_rst_n_d;
  logic sel_inc_q, sel_inc_d;
  logic ena_q, ena_d;

  // High when the current select may skip the counter reset.
  logic skip_rst;

`ifdef MUX_SEL_INCREMENTAL_EN
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic              cur_vld_q, cur_vld_d;
  logic              fast_q, fast_d;

  assign skip_rst = fast_q;
  assign cur_addr = cur_q;
`else
  assign skip_rst = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
`ifdef MUX_SEL_INCREMENTAL_EN
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    cur_vld_d = cur_vld_q;
    fast_d    = fast_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIS;
          cnt_d   = '0;
          rem_d   = addr;
`ifdef MUX_SEL_INCREMENTAL_EN
          tgt_d = addr;
          if (cur_vld_q && (addr >= cur_q)) begin
            fast_d = 1'b1;
            rem_d  = addr - cur_q;
          end else begin
            fast_d = 1'b0;
          end
`endif
        end
      end

      DIS: begin
        cnt_d = '0;
        if (skip_rst) begin
          state_d = (rem_q == '0) ? DONE : INC_HI;
        end else begin
          state_d = RST;
        end
      end

      RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = (rem_q == '0) ? DONE : INC_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      INC_HI: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = INC_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      INC_LO: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          rem_d = rem_q - ADDR_W'(1);
          // Decision uses the post-decrement count, i.e. rem_q == 1.
          state_d = (rem_q == ADDR_W'(1)) ? DONE : INC_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MUX_SEL_INCREMENTAL_EN
    // DONE lasts exactly one cycle, so this fires once per select.
    if (state_d == DONE) begin
      cur_d     = tgt_q;
      cur_vld_d = 1'b1;
    end
`endif

    // Registered outputs decoded from the state being entered.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    sel_rst_n_d = (state_d != RST);
    sel_inc_d   = (state_d == INC_HI);

    ena_d = ena_q;
    if (state_d == DIS) begin
      ena_d = 1'b0;
    end else if (state_d == DONE) begin
      ena_d = 1'b1;
    end else if ((state_q == IDLE) && stop) begin
      // start has priority: an accepted start takes the DIS branch above.
      ena_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_rst_n_q <= 1'b1;
      sel_inc_q   <= 1'b0;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sel_rst_n_q <= sel_rst_n_d;
      sel_inc_q   <= sel_inc_d;
      ena_q       <= ena_d;
    end
  end

`ifdef MUX_SEL_INCREMENTAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q     <= '0;
      cur_q     <= '0;
      cur_vld_q <= 1'b0;
      fast_q    <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      cur_vld_q <= cur_vld_d;
      fast_q    <= fast_d;
    end
  end
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = sel_inc_q;
  assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_mux_sel_driver.sv
// -----------------------------------------------------------------------------
// tb_tt_mux_sel_driver
//
// Self-checking bench for tt_mux_sel_driver. Each select is compared cycle by
// cycle against a timing model built from the select rules (cycle 1 = DIS,
// reset window, gap, 2*P cycles per pulse, DONE), plus aggregate counts of
// reset-low cycles, increment rising edges and the done cycle. Random start /
// stop / addr activity is injected while busy and must have no effect.
// Define MUX_SEL_INCREMENTAL_EN to exercise the incremental build.
// -----------------------------------------------------------------------------
module tb_tt_mux_sel_driver;

  localparam int ADDR_W = 10;
  localparam int R      = 4;
  localparam int P      = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              stop;
  logic              busy;
  logic              done;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
`ifdef MUX_SEL_INCREMENTAL_EN
  logic [ADDR_W-1:0] cur_addr;
`endif

  tt_mux_sel_driver #(
    .ADDR_W      (ADDR_W),
    .RST_CYCLES  (R),
    .PULSE_CYCLES(P)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .addr          (addr),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc  (ctrl_sel_inc),
    .ctrl_ena      (ctrl_ena)
`ifdef MUX_SEL_INCREMENTAL_EN
    ,
    .cur_addr      (cur_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last completed address and whether it is valid.
  bit m_vld = 1'b0;
  int m_cur = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done} in cycle k
  // after the start edge. off = cycles before the first increment cycle.
  function automatic logic [4:0] exp_out(int k, bit full, int off, int n);
    int   done_k;
    int   j;
    logic rn;
    logic inc;
    done_k = off + 1 + 2 * P * n;
    if (k == done_k) return 5'b10111;
    if (k > done_k)  return 5'b10100;
    rn  = !(full && (k >= 2) && (k <= R + 1));
    j   = k - off - 1;
    inc = (j >= 0) && (j < 2 * P * n) && ((j % (2 * P)) < P);
    return {rn, inc, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic run_select(input int a, input string tag, input bit with_stop);
    bit         full;
    int         n, off, done_k;
    int         mism, first_k, rises, rst_low, bad_inc, done_seen;
    logic       prev_inc;
    logic [4:0] got;
    logic [4:0] exp;
`ifdef MUX_SEL_INCREMENTAL_EN
    full = !(m_vld && (a >= m_cur));
`else
    full = 1'b1;
`endif
    n       = full ? a : a - m_cur;
    off     = full ? 1 + R + P : 1;
    done_k  = off + 1 + 2 * P * n;
    mism    = 0;
    first_k = 0;
    rises   = 0;
    rst_low = 0;
    bad_inc = 0;
    done_seen = -1;
    prev_inc  = 1'b0;

    @(negedge clk);
    start = 1'b1;
    addr  = ADDR_W'(a);
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;

    for (int k = 1; k <= done_k + 1; k++) begin
      got = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done};
      exp = exp_out(k, full, off, n);
      if (got !== exp) begin
        if (mism == 0) first_k = k;
        mism++;
      end
      if (ctrl_sel_rst_n === 1'b0) rst_low++;
      if ((ctrl_sel_inc === 1'b1) && (prev_inc === 1'b0)) rises++;
      if ((ctrl_sel_inc === 1'b1) && (ctrl_sel_rst_n === 1'b0)) bad_inc++;
      if ((done === 1'b1) && (done_seen < 0)) done_seen = k;
      prev_inc = ctrl_sel_inc;
      if (k <= done_k) begin
        // Noise while busy: must all be ignored.
        start = ($urandom_range(0, 3) == 0);
        stop  = ($urandom_range(0, 3) == 0);
        addr  = ADDR_W'($urandom);
      end else begin
        start = 1'b0;
        stop  = 1'b0;
      end
      @(negedge clk);
    end

    if (mism != 0) $display("  %s: first wave difference in cycle %0d", tag, first_k);
    check($sformatf("%s_wave_diffs", tag), mism, 0);
    check($sformatf("%s_rst_low_cycles", tag), rst_low, full ? R : 0);
    check($sformatf("%s_inc_rises", tag), rises, n);
    check($sformatf("%s_done_cycle", tag), done_seen, done_k);
    check($sformatf("%s_inc_in_rst", tag), bad_inc, 0);
    m_vld = 1'b1;
    m_cur = a;
`ifdef MUX_SEL_INCREMENTAL_EN
    check($sformatf("%s_cur_addr", tag), cur_addr, a);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    addr  = '0;
    #12;
    check("reset_outputs", {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done}, 5'b10000);
`ifdef MUX_SEL_INCREMENTAL_EN
    check("reset_cur_addr", cur_addr, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Largest address first, from a fresh reset: full sequence.
    run_select(1023, "max", 1'b0);
    run_select(3, "a3", 1'b0);
    run_select(0, "a0", 1'b0);
    run_select(4, "a4", 1'b0);
    run_select(6, "a6", 1'b0);
    run_select(1, "a1", 1'b0);

    // stop in IDLE drops ctrl_ena on the next cycle.
    check("ena_held_idle", ctrl_ena, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_drops_ena", ctrl_ena, 0);
    check("stop_not_busy", busy, 0);
    @(negedge clk);
    check("ena_stays_low", ctrl_ena, 0);

    // start and stop together: start wins.
    run_select(7, "start_stop", 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_select($urandom_range(0, 40), $sformatf("rnd%0d", i), 1'b0);
    end

    // Reset mid increment phase of addr=5.
    pulse_reset();
    @(negedge clk);
    start = 1'b1;
    addr  = ADDR_W'(5);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; (i < 100) && (ctrl_sel_inc !== 1'b1); i++) @(negedge clk);
    check("abort_reached_inc", ctrl_sel_inc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done}, 5'b10000);
`ifdef MUX_SEL_INCREMENTAL_EN
    check("abort_cur_addr", cur_addr, 0);
`endif
    m_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_select(2, "post_abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
